// File: rtl/isp_frame_ctrl_if.sv
// Signal bundle between the camera timing source and the frame controller.
// There is no valid/ready pair: a pixel is qualified by in_href && in_clken
// on a rising clk edge, and cfg_wr / err_clr are single-cycle strobes
// sampled on the rising clk edge; the controller can never stall the source.
interface isp_frame_ctrl_if #(
  parameter int CNT_W = 12
);
  // timing and control inputs to the controller
  logic             in_vsync;
  logic             in_href;
  logic             in_clken;
  logic [3:0]       cfg_mode;
  logic             cfg_wr;
  logic             err_clr;
  // registered controller outputs
  logic [3:0]       act_mode;
  logic             frame_active;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_done;
  logic [15:0]      frame_cnt;
  logic             cfg_pend;
  logic             err_width;
  logic             err_abort;
  // frame state, for observation only
  logic [1:0]       dbg_state;

  modport master (
    output in_vsync, in_href, in_clken, cfg_mode, cfg_wr, err_clr,
    input  act_mode, frame_active, pix_x, pix_y, frame_done, frame_cnt,
           cfg_pend, err_width, err_abort, dbg_state
  );

  modport slave (
    input  in_vsync, in_href, in_clken, cfg_mode, cfg_wr, err_clr,
    output act_mode, frame_active, pix_x, pix_y, frame_done, frame_cnt,
           cfg_pend, err_width, err_abort, dbg_state
  );
endinterface

// File: rtl/isp_frame_ctrl.sv
// Frame-level controller: follows vsync/href timing, counts pixel/line
// coordinates, applies the shadowed mode only at frame start and keeps
// sticky flags for wrong line widths and frames cut short by vsync.
module isp_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  isp_frame_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] W_L   = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_L   = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] X_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic             vs_dly_q, vs_dly_d;      // previous-cycle vsync
  logic             hr_dly_q, hr_dly_d;      // previous-cycle href
  logic             armed_q, armed_d;        // vsync seen low since reset
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       act_mode_q, act_mode_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             frame_active_q, frame_active_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             err_width_q, err_width_d;
  logic             err_abort_q, err_abort_d;

  logic             vs_rise, vs_fall, hr_fall, pix_acc;
  logic             new_err_width, new_err_abort;

  // A vsync already high when reset releases must not count as a rise, so
  // rises are only honoured once vsync has been observed low.
  always_comb begin
    vs_rise = bus.in_vsync && !vs_dly_q && armed_q;
    vs_fall = !bus.in_vsync && vs_dly_q;
    hr_fall = !bus.in_href && hr_dly_q;
    pix_acc = bus.in_href && bus.in_clken;
  end

  // Next-state computation for the frame FSM and every registered output.
  always_comb begin
    state_d        = state_q;
    vs_dly_d       = bus.in_vsync;
    hr_dly_d       = bus.in_href;
    armed_d        = armed_q | ~bus.in_vsync;
    shadow_d       = shadow_q;
    act_mode_d     = act_mode_q;
    cfg_pend_d     = cfg_pend_q;
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    frame_cnt_d    = frame_cnt_q;
    frame_done_d   = 1'b0;
    new_err_width  = 1'b0;
    new_err_abort  = 1'b0;

    if (vs_rise) begin
      // Start of frame wins over anything else happening this cycle.
      state_d = ST_SYNC;
      pix_x_d = '0;
      pix_y_d = '0;
      if (cfg_pend_q) begin
        act_mode_d = shadow_q;
        cfg_pend_d = 1'b0;
      end
      if (state_q == ST_ACTIVE) new_err_abort = 1'b1;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (vs_fall) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (pix_acc && (pix_x_q != X_MAX)) pix_x_d = pix_x_q + ONE;
          if (hr_fall) begin
            if (pix_x_q != W_L) new_err_width = 1'b1;
            pix_x_d = '0;
            pix_y_d = pix_y_q + ONE;
            if (pix_y_d == H_L) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
              state_d      = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    // Applied after the frame-start load so a coincident write lands in the
    // shadow for the following frame.
    if (bus.cfg_wr) begin
      shadow_d   = bus.cfg_mode;
      cfg_pend_d = 1'b1;
    end

    // Sticky flags: a new error overrides a coincident clear.
    err_width_d    = (err_width_q & ~bus.err_clr) | new_err_width;
    err_abort_d    = (err_abort_q & ~bus.err_clr) | new_err_abort;
    frame_active_d = (state_d == ST_ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      vs_dly_q       <= 1'b0;
      hr_dly_q       <= 1'b0;
      armed_q        <= 1'b0;
      shadow_q       <= 4'd0;
      act_mode_q     <= 4'd0;
      cfg_pend_q     <= 1'b0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_cnt_q    <= 16'd0;
      err_width_q    <= 1'b0;
      err_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      vs_dly_q       <= vs_dly_d;
      hr_dly_q       <= hr_dly_d;
      armed_q        <= armed_d;
      shadow_q       <= shadow_d;
      act_mode_q     <= act_mode_d;
      cfg_pend_q     <= cfg_pend_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      frame_cnt_q    <= frame_cnt_d;
      err_width_q    <= err_width_d;
      err_abort_q    <= err_abort_d;
    end
  end

  assign bus.act_mode     = act_mode_q;
  assign bus.frame_active = frame_active_q;
  assign bus.pix_x        = pix_x_q;
  assign bus.pix_y        = pix_y_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.cfg_pend     = cfg_pend_q;
  assign bus.err_width    = err_width_q;
  assign bus.err_abort    = err_abort_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Bench for isp_frame_ctrl: directed frame scenarios followed by random
// frames, all checked every cycle against a behavioural model.
module tb_isp_frame_ctrl;
  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int CNT_W = 4;
  localparam int XMAX  = (1 << CNT_W) - 1;
  localparam int PH_IDLE = 0, PH_SYNC = 1, PH_ACTIVE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  isp_frame_ctrl_if #(.CNT_W(CNT_W)) bus ();

  isp_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase, m_x, m_y, m_cnt, m_act, m_shadow;
  bit m_pend, m_done, m_ew, m_ea, m_armed, m_prev_vs, m_prev_hr;
  logic [15:0] exp_q[$];   // frame count expected at each frame_done

  task automatic model_reset();
    m_phase = PH_IDLE; m_x = 0; m_y = 0; m_cnt = 0; m_act = 0; m_shadow = 0;
    m_pend = 0; m_done = 0; m_ew = 0; m_ea = 0; m_armed = 0;
    m_prev_vs = 0; m_prev_hr = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit vs, hr, ce, rise, fall, hfall, new_ew, new_ea;
    vs = bus.in_vsync; hr = bus.in_href; ce = bus.in_clken;
    rise  = vs && !m_prev_vs && m_armed;
    fall  = !vs && m_prev_vs;
    hfall = !hr && m_prev_hr;
    new_ew = 0; new_ea = 0; m_done = 0;
    if (rise) begin
      if (m_phase == PH_ACTIVE) new_ea = 1;
      m_phase = PH_SYNC; m_x = 0; m_y = 0;
      if (m_pend) begin m_act = m_shadow; m_pend = 0; end
    end else if (m_phase == PH_SYNC) begin
      if (fall) m_phase = PH_ACTIVE;
    end else if (m_phase == PH_ACTIVE) begin
      if (hr && ce && m_x < XMAX) m_x++;
      if (hfall) begin
        new_ew = (m_x != IMG_W);
        m_x = 0;
        m_y++;
        if (m_y == IMG_H) begin
          m_done  = 1;
          m_cnt   = (m_cnt + 1) & 16'hFFFF;
          exp_q.push_back(16'(m_cnt));
          m_phase = PH_IDLE;
        end
      end
    end
    if (bus.cfg_wr) begin m_shadow = bus.cfg_mode; m_pend = 1; end
    m_ew = (m_ew && !bus.err_clr) || new_ew;
    m_ea = (m_ea && !bus.err_clr) || new_ea;
    m_armed   = m_armed || !vs;
    m_prev_vs = vs;
    m_prev_hr = hr;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("act_mode",     bus.act_mode,     m_act);
      chk("frame_active", bus.frame_active, int'(m_phase == PH_ACTIVE));
      chk("pix_x",        bus.pix_x,        m_x & XMAX);
      chk("pix_y",        bus.pix_y,        m_y & XMAX);
      chk("frame_done",   bus.frame_done,   m_done);
      chk("frame_cnt",    bus.frame_cnt,    m_cnt);
      chk("cfg_pend",     bus.cfg_pend,     m_pend);
      chk("err_width",    bus.err_width,    m_ew);
      chk("err_abort",    bus.err_abort,    m_ea);
      if (bus.frame_done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else                   chk("done_cnt", bus.frame_cnt, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(negedge clk);
    bus.cfg_wr  = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic do_vsync(input bit wr, input logic [3:0] mode);
    bus.in_vsync = 1'b1;
    bus.in_href  = 1'b0;
    if (wr) begin bus.cfg_wr = 1'b1; bus.cfg_mode = mode; end
    repeat (3) next();
    bus.in_vsync = 1'b0;
    repeat (2) next();
  endtask

  task automatic do_line(input int npix, input bit clr_at_fall, input bit sweep);
    int acc, tries;
    bit ce;
    acc = 0; tries = 0;
    bus.in_href = 1'b1;
    if (npix == 0) begin
      bus.in_clken = 1'b0;
      next();
    end else begin
      while (acc < npix) begin
        ce = ($urandom_range(0, 3) != 0) || (tries >= 3);
        bus.in_clken = ce;
        if (ce) begin
          if (sweep) chk("pix_x_sweep", bus.pix_x, (acc < XMAX) ? acc : XMAX);
          acc++; tries = 0;
        end else tries++;
        next();
      end
    end
    bus.in_href  = 1'b0;
    bus.in_clken = 1'($urandom_range(0, 1));
    if (clr_at_fall) bus.err_clr = 1'b1;
    next();
    repeat ($urandom_range(1, 3)) next();
    bus.in_clken = 1'b0;
  endtask

  task automatic do_frame(input int nl, input int bad_idx, input int bad_len,
                          input bit clr_bad, input bit wr_rise, input logic [3:0] mode_rise,
                          input int wr_line, input logic [3:0] mode_mid);
    do_vsync(wr_rise, mode_rise);
    for (int l = 0; l < nl; l++) begin
      if (l == wr_line) begin
        bus.cfg_wr = 1'b1; bus.cfg_mode = mode_mid; next();
      end
      do_line((l == bad_idx) ? bad_len : IMG_W, (l == bad_idx) && clr_bad, l < IMG_H);
    end
    repeat (2) next();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_vsync = 0; bus.in_href = 0; bus.in_clken = 0;
    bus.cfg_mode = 0; bus.cfg_wr = 0; bus.err_clr = 0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) next();
    rst_n = 1'b1;
    chk("rst_act_mode",  bus.act_mode, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_active",    bus.frame_active, 0);
    chk("rst_pix_x",     bus.pix_x, 0);
    chk("rst_cfg_pend",  bus.cfg_pend, 0);
    repeat (2) next();

    // three clean frames, mode 5 written during frame 1
    do_frame(4, -1, 0, 0, 0, 4'd0, 2, 4'd5);
    chk("f1_act_mode", bus.act_mode, 0);
    chk("f1_cfg_pend", bus.cfg_pend, 1);
    chk("f1_cnt",      bus.frame_cnt, 1);
    do_frame(4, -1, 0, 0, 0, 4'd0, -1, 4'd0);
    chk("f2_act_mode", bus.act_mode, 5);
    chk("f2_cfg_pend", bus.cfg_pend, 0);
    do_frame(4, -1, 0, 0, 0, 4'd0, -1, 4'd0);
    chk("f3_cnt",       bus.frame_cnt, 3);
    chk("f3_err_width", bus.err_width, 0);
    chk("f3_err_abort", bus.err_abort, 0);

    // shadow 5 pending, mode 9 written on the vsync-rise cycle, 7-pixel line
    bus.cfg_wr = 1'b1; bus.cfg_mode = 4'd5; next();
    do_frame(4, 1, 7, 0, 1, 4'd9, -1, 4'd0);
    chk("f4_act_mode",  bus.act_mode, 5);
    chk("f4_cfg_pend",  bus.cfg_pend, 1);
    chk("f4_err_width", bus.err_width, 1);
    do_frame(4, -1, 0, 0, 0, 4'd0, -1, 4'd0);
    chk("f5_act_mode",  bus.act_mode, 9);
    chk("f5_err_sticky", bus.err_width, 1);
    bus.err_clr = 1'b1; next();
    chk("clr_err_width", bus.err_width, 0);

    // zero-length line with a coincident clear
    do_frame(4, 2, 0, 1, 0, 4'd0, -1, 4'd0);
    chk("f6_err_width", bus.err_width, 1);
    chk("f6_cnt",       bus.frame_cnt, 6);

    // frame cut short after two lines, then a full frame
    do_frame(2, -1, 0, 0, 0, 4'd0, -1, 4'd0);
    chk("abort_cnt_hold", bus.frame_cnt, 6);
    do_frame(4, -1, 0, 0, 0, 4'd0, -1, 4'd0);
    chk("abort_flag", bus.err_abort, 1);
    chk("f8_cnt",     bus.frame_cnt, 7);

    // reset mid-line with vsync held high across the release
    do_vsync(0, 4'd0);
    bus.in_href = 1'b1; bus.in_clken = 1'b1;
    repeat (3) next();
    bus.in_vsync = 1'b1;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    next();
    chk("mid_rst_cnt",      bus.frame_cnt, 0);
    chk("mid_rst_pix_x",    bus.pix_x, 0);
    chk("mid_rst_err",      bus.err_width, 0);
    bus.in_href = 1'b0; bus.in_clken = 1'b0;
    repeat (3) next();
    do_line(IMG_W, 0, 0);
    chk("vs_held_active", bus.frame_active, 0);
    chk("vs_held_pix_y",  bus.pix_y, 0);
    bus.in_vsync = 1'b0;
    repeat (2) next();
    do_frame(4, -1, 0, 0, 0, 4'd0, -1, 4'd0);
    chk("post_rst_cnt", bus.frame_cnt, 1);

    // random frames
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 3) == 0) begin bus.err_clr = 1'b1; next(); end
      do_frame($urandom_range(1, 5),
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1,
               $urandom_range(0, 17), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1,
               4'($urandom_range(0, 15)));
    end
    repeat (4) next();
    chk("done_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
